// File: rtl/systolic_mm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_sequencer_if
// Brief    : Job, operand and result bundle between the requester, the
//            systolic_mm_sequencer and the N x N systolic array.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_mm_sequencer_if #(
    parameter int N            = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_WIDTH = 16
);
    logic                    start;
    logic [DATA_WIDTH-1:0]   a_in          [0:N-1][0:N-1];
    logic [DATA_WIDTH-1:0]   b_in          [0:N-1][0:N-1];
    logic                    busy;
    logic [DATA_WIDTH-1:0]   arr_a         [0:N-1][0:N-1];
    logic                    arr_valid_a   [0:N-1][0:N-1];
    logic [DATA_WIDTH-1:0]   arr_b         [0:N-1][0:N-1];
    logic                    arr_valid_b   [0:N-1][0:N-1];
    logic [OUTPUT_WIDTH-1:0] arr_c         [0:N-1][0:N-1];
    logic                    arr_valid_out;
    logic [OUTPUT_WIDTH-1:0] c_out         [0:N-1][0:N-1];
    logic                    result_valid;
    logic                    result_ready;
    logic                    error;
    logic [15:0]             job_cycles;

    // Sequencer side
    modport slave (
        input  start, a_in, b_in, arr_c, arr_valid_out, result_ready,
        output busy, arr_a, arr_valid_a, arr_b, arr_valid_b,
               c_out, result_valid, error, job_cycles
    );

    // Requester / array side
    modport master (
        output start, a_in, b_in, arr_c, arr_valid_out, result_ready,
        input  busy, arr_a, arr_valid_a, arr_b, arr_valid_b,
               c_out, result_valid, error, job_cycles
    );
endinterface

`default_nettype wire

// File: rtl/systolic_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_sequencer
// Brief    : Job controller for an N x N systolic matrix multiplier: feeds
//            operands for FEED_CYCLES, waits for the result with a timeout and
//            holds it under valid/ready. Optional macro SYSTOLIC_MM_SEQ_PERF_EN
//            enables the job_cycles performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mm_sequencer #(
    parameter int N             = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int OUTPUT_WIDTH  = 16,
    parameter int FEED_CYCLES   = N,
    parameter int DRAIN_TIMEOUT = 4 * N
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_mm_sequencer_if.slave bus
);
    localparam int c_cnt_max = (FEED_CYCLES > DRAIN_TIMEOUT) ? FEED_CYCLES : DRAIN_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    generate
        if (FEED_CYCLES < 1) begin : g_chk_feed
            $error("FEED_CYCLES must be >= 1");
        end
        if (DRAIN_TIMEOUT < 1) begin : g_chk_drain
            $error("DRAIN_TIMEOUT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_feed_last;
    logic               w_drain_last;

    assign w_feed_last  = (r_cnt == c_cnt_w'(FEED_CYCLES - 1));
    assign w_drain_last = (r_cnt == c_cnt_w'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)                          w_next = S_FEED;
            S_FEED:  if (w_feed_last)                        w_next = S_DRAIN;
            S_DRAIN: if (bus.arr_valid_out || w_drain_last)  w_next = S_DONE;
            S_DONE:  if (bus.result_ready)                   w_next = S_IDLE;
            default:                                         w_next = S_IDLE;
        endcase
    end

    // The arr_a/arr_b registers double as the captured operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    bus.arr_a[i][j]       <= {DATA_WIDTH{1'b0}};
                    bus.arr_b[i][j]       <= {DATA_WIDTH{1'b0}};
                    bus.arr_valid_a[i][j] <= 1'b0;
                    bus.arr_valid_b[i][j] <= 1'b0;
                    bus.c_out[i][j]       <= {OUTPUT_WIDTH{1'b0}};
                end
            end
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.error        <= 1'b0;
            r_cnt            <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                bus.arr_a[i][j]       <= bus.a_in[i][j];
                                bus.arr_b[i][j]       <= bus.b_in[i][j];
                                bus.arr_valid_a[i][j] <= 1'b1;
                                bus.arr_valid_b[i][j] <= 1'b1;
                            end
                        end
                        bus.busy <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_FEED: begin
                    if (w_feed_last) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                bus.arr_a[i][j]       <= {DATA_WIDTH{1'b0}};
                                bus.arr_b[i][j]       <= {DATA_WIDTH{1'b0}};
                                bus.arr_valid_a[i][j] <= 1'b0;
                                bus.arr_valid_b[i][j] <= 1'b0;
                            end
                        end
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A valid on the final drain cycle takes priority over the timeout.
                    if (bus.arr_valid_out) begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                bus.c_out[i][j] <= bus.arr_c[i][j];
                        bus.result_valid <= 1'b1;
                        bus.error        <= 1'b0;
                    end else if (w_drain_last) begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                bus.c_out[i][j] <= {OUTPUT_WIDTH{1'b0}};
                        bus.result_valid <= 1'b1;
                        bus.error        <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        bus.error        <= 1'b0;
                        bus.busy         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYSTOLIC_MM_SEQ_PERF_EN
    logic [15:0] r_perf;
    logic [15:0] w_perf_next;
    logic        w_done_go;

    assign w_perf_next = (r_perf == 16'hFFFF) ? r_perf : r_perf + 16'd1;
    assign w_done_go   = (r_state == S_DRAIN) && (w_next == S_DONE);

    // The capture cycle itself is counted, so job_cycles = feed + drain cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf         <= 16'd0;
            bus.job_cycles <= 16'd0;
        end else begin
            if (r_state == S_IDLE && bus.start)
                r_perf <= 16'd0;
            else if (r_state == S_FEED || r_state == S_DRAIN)
                r_perf <= w_perf_next;
            if (w_done_go)
                bus.job_cycles <= w_perf_next;
        end
    end
`else
    assign bus.job_cycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mm_sequencer
// Brief    : Directed bench with array model and result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_sequencer;
    localparam int N  = 5;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int FC = N;
    localparam int DT = 4 * N;
    localparam int NN = N * N;
`ifdef SYSTOLIC_MM_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef logic [NN-1:0][OW-1:0] cvec_t;
    typedef struct packed {
        cvec_t       c;
        logic        err;
        logic [15:0] cyc;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_mm_sequencer_if #(.N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) bus ();

    systolic_mm_sequencer #(
        .N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW),
        .FEED_CYCLES(FC), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    opa[N][N];
    int    opb[N][N];
    cvec_t model_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag, input cvec_t obs, input cvec_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cvec_t dut_c();
        cvec_t r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[i*N+j] = bus.c_out[i][j];
        return r;
    endfunction

    function automatic logic all_valid();
        logic r = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r &= bus.arr_valid_a[i][j] & bus.arr_valid_b[i][j];
        return r;
    endfunction

    function automatic logic any_arr_activity();
        logic r = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r |= bus.arr_valid_a[i][j] | bus.arr_valid_b[i][j]
                   | (|bus.arr_a[i][j]) | (|bus.arr_b[i][j]);
        return r;
    endfunction

    function automatic logic ops_match();
        logic r = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r &= (bus.arr_a[i][j] === DW'(opa[i][j])) && (bus.arr_b[i][j] === DW'(opb[i][j]));
        return r;
    endfunction

    // Operands: nominal pattern (A = 1..25, B = 25..1) or random; reference C by plain matmul.
    task automatic load(input bit nominal);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                opa[i][j] = nominal ? (i*N + j + 1) : int'($urandom_range(0, 255));
                opb[i][j] = nominal ? (NN - (i*N + j)) : int'($urandom_range(0, 255));
                bus.a_in[i][j] = DW'(opa[i][j]);
                bus.b_in[i][j] = DW'(opb[i][j]);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) s += opa[i][k] * opb[k][j];
                model_c[i*N+j] = OW'(s);
            end
    endtask

    // d = drain edge (1-based) on which the array model presents arr_valid_out; 0 = never.
    task automatic run_job(input bit nominal, input int d, input string tag);
        exp_t e;
        bit   got;
        int   lat;
        bit   timed_out;
        load(nominal);
        timed_out = !(d >= 1 && d <= DT);
        e.c   = timed_out ? '0 : model_c;
        e.err = timed_out;
        e.lat = timed_out ? 8'(DT) : 8'(d);
        e.cyc = PERF ? 16'(FC + int'(e.lat)) : 16'd0;
        sb.push_back(e);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < FC; k++) begin
            check({tag, "_feed_valid"}, all_valid(), 1'b1);
            check({tag, "_feed_busy"}, bus.busy, 1'b1);
            if (k == 0) check({tag, "_feed_operands"}, ops_match(), 1'b1);
            tick();
        end
        check({tag, "_feed_cleared"}, any_arr_activity(), 1'b0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                bus.arr_c[i][j] = model_c[i*N+j];
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= DT + 5 && !got; i++) begin
            bus.arr_valid_out = (i == d);
            tick();
            if (bus.result_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        bus.arr_valid_out = 1'b0;
        check({tag, "_result_wait"}, bus.result_valid, 1'b1);
        if (got) begin
            e = sb.pop_front();
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check({tag, "_error"}, bus.error, e.err);
            check_c({tag, "_c_out"}, dut_c(), e.c);
            check({tag, "_job_cycles"}, bus.job_cycles, e.cyc);
        end
    endtask

    task automatic release_result(input bit start_same, input string tag);
        bus.result_ready = 1'b1;
        bus.start        = start_same;
        tick();
        bus.result_ready = 1'b0;
        check({tag, "_rel_valid"}, bus.result_valid, 1'b0);
        check({tag, "_rel_busy"}, bus.busy, 1'b0);
        check({tag, "_rel_error"}, bus.error, 1'b0);
        check({tag, "_rel_no_feed"}, any_arr_activity(), 1'b0);
    endtask

    initial begin
        int    row0[N];
        cvec_t snap;
        row0 = '{175, 160, 145, 130, 115};

        bus.start = 1'b1;
        bus.result_ready = 1'b0;
        bus.arr_valid_out = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                bus.a_in[i][j]  = DW'(i + j + 1);
                bus.b_in[i][j]  = DW'(i + j + 2);
                bus.arr_c[i][j] = OW'(i * j + 3);
            end

        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", bus.busy, 1'b0);
        check("reset_result_valid", bus.result_valid, 1'b0);
        check("reset_error", bus.error, 1'b0);
        check("reset_job_cycles", bus.job_cycles, 16'd0);
        check("reset_arr", any_arr_activity(), 1'b0);
        check_c("reset_c_out", dut_c(), '0);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();

        run_job(1'b1, 3, "nominal");
        for (int j = 0; j < N; j++)
            check("nominal_row0", bus.c_out[0][j], 64'(row0[j]));

        snap = dut_c();
        for (int k = 0; k < 10; k++) begin
            bus.start = (k == 4);
            tick();
            check("hold_valid", bus.result_valid, 1'b1);
            check("hold_busy", bus.busy, 1'b1);
            check("hold_error", bus.error, 1'b0);
            check("hold_no_feed", any_arr_activity(), 1'b0);
            check_c("hold_c_stable", dut_c(), snap);
        end
        bus.start = 1'b0;
        release_result(1'b1, "nominal");

        run_job(1'b0, 0, "timeout");
        release_result(1'b0, "timeout");

        run_job(1'b0, DT, "boundary");
        release_result(1'b0, "boundary");

        load(1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_arr", any_arr_activity(), 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_result_valid", bus.result_valid, 1'b0);
        check("midrst_job_cycles", bus.job_cycles, 16'd0);
        tick();
        check("midrst_stays_idle", any_arr_activity(), 1'b0);

        run_job(1'b0, 2, "post_reset");
        release_result(1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule

`default_nettype wire
